// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory requester: FSM states, funct3 codes
// and the byte-lane mask helper.
package mem_pkg;

  localparam int unsigned Xlen = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } state_e;

  localparam logic [2:0] F3D       = 3'b011;
  localparam logic [2:0] F3Illegal = 3'b111;

  localparam logic [1:0] SzB = 2'b00;
  localparam logic [1:0] SzH = 2'b01;
  localparam logic [1:0] SzW = 2'b10;
  localparam logic [1:0] SzD = 2'b11;

  // Right-aligned mask covering an access of the given size.
  function automatic logic [Xlen-1:0] size_mask(input logic [1:0] size);
    logic [Xlen-1:0] m;
    unique case (size)
      SzB:     m = Xlen'(64'h0000_0000_0000_00ff);
      SzH:     m = Xlen'(64'h0000_0000_0000_ffff);
      SzW:     m = Xlen'(64'h0000_0000_ffff_ffff);
      default: m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: extracts/extends a load field from a memory word
// and merges sub-word store data into a memory word.
module mem_align
  import mem_pkg::*;
(
  input  logic [Xlen-1:0] word_i,
  input  logic [Xlen-1:0] wdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      offset_i,
  output logic [Xlen-1:0] load_o,
  output logic [Xlen-1:0] store_o
);

  logic [5:0]      shamt;
  logic [Xlen-1:0] mask;
  logic [Xlen-1:0] field;

  assign shamt = {offset_i, 3'b000};

  always_comb begin
    mask   = size_mask(funct3_i[1:0]);
    field  = (word_i >> shamt) & mask;
    load_o = field;
    // funct3[2] selects the unsigned variants
    if (!funct3_i[2]) begin
      unique case (funct3_i[1:0])
        SzB:     load_o = {{(Xlen-8){field[7]}}, field[7:0]};
        SzH:     load_o = {{(Xlen-16){field[15]}}, field[15:0]};
        SzW:     load_o = {{(Xlen-32){field[31]}}, field[31:0]};
        default: load_o = field;
      endcase
    end
    store_o = (word_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store requester for a word-indexed 64-bit memory: checks each request,
// reads the word, merges or extracts sub-word data and returns a one-cycle response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned XLEN      = Xlen,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_wr
);

  localparam int unsigned IdxW  = $clog2(MEM_WORDS);
  localparam int unsigned AddrW = IdxW + 3;

  state_e state_q, state_d;

  logic            we_q;
  logic [2:0]      funct3_q;
  logic [2:0]      offset_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic            resp_err_q;

  logic            misaligned;
  logic            out_of_range;
  logic            bad_funct3;
  logic            req_err;
  logic            is_sd;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_data;

  always_comb begin
    unique case (req_funct3[1:0])
      SzB:     misaligned = 1'b0;
      SzH:     misaligned = req_addr[0];
      SzW:     misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    out_of_range = (req_addr >> 3) >= XLEN'(MEM_WORDS);
    bad_funct3   = (req_funct3 == F3Illegal) || (req_we && req_funct3[2]);
    req_err      = misaligned || out_of_range || bad_funct3;
    is_sd        = req_we && (req_funct3 == F3D);
  end

  mem_align u_align (
    .word_i   (mem_rdata),
    .wdata_i  (wdata_q),
    .funct3_i (funct3_q),
    .offset_i (offset_q),
    .load_o   (load_data),
    .store_o  (store_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err)    state_d = StResp;
          else if (is_sd) state_d = StWrite;
          else            state_d = StRead;
        end
      end
      StRead:  state_d = we_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Merged store data is registered at the end of READ so WRITE drives a stable word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      funct3_q     <= '0;
      offset_q     <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            offset_q <= req_addr[2:0];
            wdata_q  <= req_wdata;
            if (req_err) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              mem_addr_q <= XLEN'(req_addr[AddrW-1:3]);
              if (is_sd) mem_wdata_q <= req_wdata;
            end
          end
        end
        StRead: begin
          if (we_q) begin
            mem_wdata_q <= store_data;
          end else begin
            resp_rdata_q <= load_data;
            resp_err_q   <= 1'b0;
          end
        end
        StWrite: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign mem_wr     = (state_q == StWrite);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
